// File: rtl/result_drain_buffer.sv
// Collects BUFFER_SIZE accumulator words from one PE column, then drains them in
// arrival order, narrowed to DATA_WIDTH. Define RESULT_DRAIN_SATURATE_EN to saturate instead of truncate.
module result_drain_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int BUFFER_SIZE = 9
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [ACC_WIDTH-1:0]               data_in,
  input  logic                               flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               out_last,
  output logic [$clog2(BUFFER_SIZE+1)-1:0]   count
);

  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam int PW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  mem [BUFFER_SIZE];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         rd_idx;
  logic [PW-1:0]         wr_idx;
  logic [ACC_WIDTH-1:0]  rd_word;
  logic [DATA_WIDTH-1:0] rd_conv;
  logic [CW-1:0]         count_fill;
  logic                  accept;
  logic                  handshake;
  logic                  start_drain;

  assign in_ready   = (state_q != DRAIN);
  assign accept     = in_valid && in_ready;
  assign handshake  = out_valid && out_ready;
  assign wr_idx     = PW'(count);
  assign count_fill = accept ? count + CW'(1) : count;

  // Only a single-entry buffer drains straight out of IDLE, so the word comes from data_in.
  assign rd_idx  = (state_q == DRAIN) ? rd_ptr + PW'(1) : '0;
  assign rd_word = (state_q == IDLE) ? data_in : mem[rd_idx];

`ifdef RESULT_DRAIN_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    rd_conv = rd_word[DATA_WIDTH-1:0];
    if ($signed(rd_word) > SAT_MAX)
      rd_conv = SAT_MAX[DATA_WIDTH-1:0];
    else if ($signed(rd_word) < SAT_MIN)
      rd_conv = SAT_MIN[DATA_WIDTH-1:0];
  end
`else
  logic [ACC_WIDTH-DATA_WIDTH:0] unused_hi;
  assign unused_hi = rd_word[ACC_WIDTH-1:DATA_WIDTH-1];
  assign rd_conv   = rd_word[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_drain = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = (BUFFER_SIZE == 1) ? DRAIN : FILL;
          start_drain = (BUFFER_SIZE == 1);
        end
      end
      FILL: begin
        if (flush || (accept && count == CW'(BUFFER_SIZE - 1))) begin
          state_d     = DRAIN;
          start_drain = 1'b1;
        end
      end
      DRAIN: begin
        if (handshake && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BUFFER_SIZE; i++) mem[i] <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      data_out  <= '0;
    end else begin
      if (accept) begin
        mem[wr_idx] <= data_in;
        count       <= count_fill;
      end
      if (start_drain) begin
        rd_ptr    <= '0;
        out_valid <= 1'b1;
        out_last  <= (count_fill == CW'(1));
        data_out  <= rd_conv;
      end else if (handshake) begin
        count <= count - CW'(1);
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          data_out  <= '0;
        end else begin
          rd_ptr   <= rd_ptr + PW'(1);
          data_out <= rd_conv;
          out_last <= (count == CW'(2));
        end
      end
    end
  end

endmodule

// File: doc/result_drain_buffer.md
Name: result_drain_buffer

Overview:
- Output-side counterpart of the input shift/recirculate buffers that feed the systolic array.
- Collects the serial accumulator stream leaving one PE column: BUFFER_SIZE words, ACC_WIDTH wide.
- Stores them, then emits them in arrival order, narrowed to DATA_WIDTH, over a valid/ready interface to the writeback path.
- Input is back-pressured while draining.

Parameters:
- DATA_WIDTH, 8, output word width (signed).
- ACC_WIDTH, 16, input accumulator width (signed, must be >= DATA_WIDTH).
- BUFFER_SIZE, 9, words per column result; a full buffer triggers drain.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  data_in valid.
- in_ready  out  1  buffer can accept a word.
- data_in  in  ACC_WIDTH  accumulator result from PE column.
- flush  in  1  drain a partially filled buffer.
- out_valid  out  1  data_out valid.
- out_ready  in  1  downstream accepts data_out.
- data_out  out  DATA_WIDTH  narrowed result.
- out_last  out  1  marks final word of the current drain.
- count  out  $clog2(BUFFER_SIZE+1)  words currently held.

Behaviour:
- Single clock; rst is asynchronous and active-high.
- Reset state:
  - State is IDLE.
  - out_valid, out_last, data_out, count and all buffer entries are 0.
  - in_ready = 1; it is decoded from state and reads 1 during and after reset.
- States: IDLE, FILL, DRAIN. An accept is in_valid && in_ready. in_ready = 1 in IDLE and FILL, 0 in DRAIN.
- IDLE:
  - An accept writes buffer[0], sets count=1, and moves to FILL.
  - If BUFFER_SIZE==1, it moves straight to DRAIN instead.
  - flush in IDLE is ignored.
- FILL:
  - An accept writes buffer[count] and increments count.
  - The accept that makes count==BUFFER_SIZE moves to DRAIN.
  - flush moves to DRAIN with the words held. If an accept happens in the same cycle, the word is stored first and is included in the drain.
- Entering DRAIN:
  - rd_ptr=0, drain_len=count after the update.
  - out_valid rises on the cycle after the transition edge (1-cycle latency from the last accept or flush).
  - data_out = conv(buffer[0]); out_last = (drain_len==1).
- DRAIN:
  - data_out and out_last are registered and stay stable while out_valid && !out_ready.
  - Each handshake (out_valid && out_ready) advances rd_ptr, decrements count, and loads the next word into data_out.
  - out_last is high exactly on word drain_len-1.
  - The handshake on out_last returns to IDLE: out_valid=0 and out_last=0 next cycle, count=0, in_ready=1.
  - A new accept is possible on the cycle after that handshake; there is no overlap of fill and drain.
- in_valid while in DRAIN: the word is not accepted; the sender must hold it.
- flush in DRAIN is ignored.
- conv(): signed narrowing from ACC_WIDTH to DATA_WIDTH, see Optional Feature.
- Reset mid-operation: immediately aborts FILL or DRAIN and returns all outputs to their reset values. Held data is lost.
- Buffer entries beyond drain_len are never emitted.

Optional Feature:
- Macro: RESULT_DRAIN_SATURATE_EN.
- Defined: conv() saturates the signed value to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: conv() truncates, keeping data_in[DATA_WIDTH-1:0].

Test Plan:
- Full buffer, no back-pressure.
  - Stimulus: BUFFER_SIZE=4, ACC_WIDTH=16, DATA_WIDTH=8; in_valid back-to-back with 0x0011, 0x0022, 0x0033, 0x0044; out_ready=1.
  - Response: out_valid rises the cycle after the 4th accept; data_out is 0x11, 0x22, 0x33, 0x44 on consecutive cycles; out_last only with 0x44; in_ready=0 throughout the drain; count goes 4,3,2,1,0; then IDLE.
- Back-pressure.
  - Stimulus: same fill; out_ready pattern 1,0,0,1,1,1.
  - Response: data_out holds 0x22 with out_valid=1 for both stall cycles; no word is lost or duplicated; 4 handshakes total.
- Flush of a partial buffer.
  - Stimulus: accept 0x0005, 0x0006, then pulse flush with in_valid=0.
  - Response: two outputs, 0x05 then 0x06 with out_last; count goes 2→1→0.
- Flush with a concurrent accept.
  - Stimulus: after two words, flush and in_valid with 0x0007 in the same cycle.
  - Response: 0x05, 0x06, 0x07 emitted; out_last on 0x07.
- Narrowing.
  - Stimulus: words 0x0190 (+400) and 0xFF00 (-256).
  - Response: with RESULT_DRAIN_SATURATE_EN, 0x7F and 0x80; without it, 0x90 and 0x00.
- Reset mid-drain.
  - Stimulus: assert rst asynchronously after the first output handshake.
  - Response: out_valid=0, count=0, in_ready=1 immediately. A subsequent 4-word fill drains correctly starting from its own first word.
